stream_stall_injector: RTL and testbench

Pass-through ready-valid stage that inserts pseudo-random stall cycles into a stream while keeping the handshake protocol legal. It sits directly upstream of a stream sink or watchdog in a testbench or debug build, and is used to stress back-pressure paths and confirm that inactivity detection fires only on real deadlocks. An LFSR drives all stall decisions, so a given seed always produces the same stall pattern.

---
 rtl/stream_stall_injector.sv | 121 ++++++++++++
 tb/tb_stream_stall_injector.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_stall_injector.sv
// Pass-through ready/valid stage that gates the handshake with pseudo-random
// stall windows. An LFSR makes every stall decision, so a fixed seed always
// gives the same stall pattern. The data path has no storage and adds no latency.
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous reset, active-low (also suppresses stalling)
//   enable_i     stall injection enable; low = pure pass-through
//   valid_i      upstream valid          ready_o  upstream ready
//   data_i       upstream payload        data_o   downstream payload (= data_i)
//   valid_o      downstream valid        ready_i  downstream ready
//   stalling_o   a stall is applied in the current cycle
//   stall_cnt_o  saturating count of stalled cycles
module stream_stall_injector #(
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned StallThreshold = 64,
    parameter int unsigned StallLenWidth  = 3,
    parameter int unsigned CntWidth       = 32,
    parameter logic [15:0] LfsrSeed       = 16'hACE1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [DataWidth-1:0] data_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 stalling_o,
    output logic [CntWidth-1:0]  stall_cnt_o
);

    // An all-zero seed would lock the LFSR, so it is replaced.
    localparam logic [15:0] Seed   = (LfsrSeed == 16'h0000) ? 16'h0001 : LfsrSeed;
    localparam logic [8:0]  Thresh = 9'(StallThreshold);

    typedef enum logic {
        PASS  = 1'b0,
        STALL = 1'b1
    } state_e;

    state_e                   state_q, state_d;
    logic [StallLenWidth-1:0] len_q, len_d;
    logic [15:0]              lfsr_q, lfsr_d;
    logic                     hold_q, hold_d;
    logic [CntWidth-1:0]      cnt_q, cnt_d;

    logic                     lfsr_fb;
    logic                     below_thr;
    logic                     start_c;
    logic                     stalling_c;
    logic [StallLenWidth-1:0] len_m1;

    // Stall decision: only registered state plus enable, never ready_i/valid_i.
    always_comb begin
        lfsr_fb    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        below_thr  = {1'b0, lfsr_q[7:0]} < Thresh;
        len_m1     = lfsr_q[8 +: StallLenWidth];
        start_c    = (state_q == PASS) & rst_ni & enable_i & ~hold_q & below_thr;
        stalling_c = rst_ni & enable_i & ((state_q == STALL) | start_c);
    end

    // Handshake gating; the payload is a straight wire.
    always_comb begin
        valid_o     = valid_i & ~stalling_c;
        ready_o     = ready_i & ~stalling_c;
        data_o      = data_i;
        stalling_o  = stalling_c;
        stall_cnt_o = cnt_q;
    end

    // Next-state logic. len_q holds the stall cycles left after the current one.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        lfsr_d  = lfsr_q;
        hold_d  = valid_o & ~ready_i;
        cnt_d   = cnt_q;

        if (enable_i) begin
            lfsr_d = {lfsr_q[14:0], lfsr_fb};
        end

        if (!enable_i) begin
            state_d = PASS;
            len_d   = '0;
        end else if (state_q == STALL) begin
            len_d = len_q - StallLenWidth'(1);
            if (len_q == StallLenWidth'(1)) begin
                state_d = PASS;
            end
        end else if (start_c && (len_m1 != '0)) begin
            // A one-cycle stall is covered entirely by the start cycle.
            state_d = STALL;
            len_d   = len_m1;
        end

        if (stalling_c && (cnt_q != '1)) begin
            cnt_d = cnt_q + CntWidth'(1);
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= PASS;
            len_q   <= '0;
            lfsr_q  <= Seed;
            hold_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            lfsr_q  <= lfsr_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_stream_stall_injector.sv
// Bench for stream_stall_injector: three instances share one stimulus stream
// (threshold 0, threshold 256 with a 4-bit counter, threshold 128). Every cycle
// all three are compared against a behavioural stall model; directed tables and
// sequences cover the enable window, hold protection, saturation and reset.
module tb_stream_stall_injector;

    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en, vin, rin;
    logic [DW-1:0] din;

    logic          vo [3];
    logic          ro [3];
    logic          so [3];
    logic [DW-1:0] dout [3];
    logic [31:0]   cnt_a, cnt_c;
    logic [3:0]    cnt_b;

    always #5 clk = ~clk;

    stream_stall_injector #(.DataWidth(DW), .StallThreshold(0), .StallLenWidth(3), .CntWidth(32))
    u_a (.clk_i(clk), .rst_ni(rst_n), .enable_i(en), .valid_i(vin), .ready_o(ro[0]),
         .data_i(din), .valid_o(vo[0]), .ready_i(rin), .data_o(dout[0]),
         .stalling_o(so[0]), .stall_cnt_o(cnt_a));

    stream_stall_injector #(.DataWidth(DW), .StallThreshold(256), .StallLenWidth(3), .CntWidth(4))
    u_b (.clk_i(clk), .rst_ni(rst_n), .enable_i(en), .valid_i(vin), .ready_o(ro[1]),
         .data_i(din), .valid_o(vo[1]), .ready_i(rin), .data_o(dout[1]),
         .stalling_o(so[1]), .stall_cnt_o(cnt_b));

    stream_stall_injector #(.DataWidth(DW), .StallThreshold(128), .StallLenWidth(3), .CntWidth(32))
    u_c (.clk_i(clk), .rst_ni(rst_n), .enable_i(en), .valid_i(vin), .ready_o(ro[2]),
         .data_i(din), .valid_o(vo[2]), .ready_i(rin), .data_o(dout[2]),
         .stalling_o(so[2]), .stall_cnt_o(cnt_c));

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: remaining stall cycles, hold flag, LFSR, counter.
    int unsigned  thr_m [3];
    logic [63:0]  cmax_m [3];
    logic [15:0]  m_lfsr [3];
    int unsigned  m_rem [3];
    bit           m_hold [3];
    logic [63:0]  m_cnt [3];
    bit           m_st [3];

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    function automatic logic [63:0] cnt_of(input int i);
        if (i == 0) return 64'(cnt_a);
        if (i == 1) return 64'(cnt_b);
        return 64'(cnt_c);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_lfsr[i] = 16'hACE1;
            m_rem[i]  = 0;
            m_hold[i] = 1'b0;
            m_cnt[i]  = '0;
        end
    endtask

    // Stress-mode bookkeeping for instance C.
    bit          stress_on = 1'b0;
    bit          prev_vo = 1'b0, prev_rin = 1'b0;
    logic [DW-1:0] prev_do = '0;
    bit          up_hs = 1'b0;
    int          beats = 0;
    int          wd = 0, wd_max = 0;
    logic [DW-1:0] sb_q [$];

    // Negedge: compare every instance with the model for the current inputs.
    task automatic sample();
        bit st;
        @(negedge clk);
        if (!rst_n) model_reset();
        for (int i = 0; i < 3; i++) begin
            st = rst_n && en &&
                 (m_rem[i] > 0 || (!m_hold[i] && int'(m_lfsr[i][7:0]) < int'(thr_m[i])));
            m_st[i] = st;
            check($sformatf("model_hs[%0d]", i), {61'b0, vo[i], ro[i], so[i]},
                  {61'b0, vin & ~st, rin & ~st, st});
            check($sformatf("model_data[%0d]", i), 64'(dout[i]), 64'(din));
            check($sformatf("model_cnt[%0d]", i), cnt_of(i), m_cnt[i]);
        end
        if (stress_on) begin
            if (prev_vo && !prev_rin) begin
                check("valid_hold", {63'b0, vo[2]}, 64'd1);
                check("data_hold", 64'(dout[2]), 64'(prev_do));
            end
            if (vin && ro[2]) sb_q.push_back(din);
            if (vo[2] && rin) begin
                beats++;
                if (sb_q.size() == 0) check("sb_empty", 64'd0, 64'd1);
                else check("sb_data", 64'(dout[2]), 64'(sb_q.pop_front()));
            end
            if (vin && !(vo[2] && rin)) wd++;
            else wd = 0;
            if (wd > wd_max) wd_max = wd;
        end
        prev_vo  = vo[2];
        prev_rin = rin;
        prev_do  = dout[2];
        up_hs    = vin && ro[2];
    endtask

    // Posedge: advance the model, then release inputs for the next cycle.
    task automatic advance();
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                model_reset();
            end else begin
                if (m_st[i] && m_cnt[i] < cmax_m[i]) m_cnt[i]++;
                m_hold[i] = (vin && !m_st[i]) && !rin;
                if (!en) m_rem[i] = 0;
                else if (m_st[i]) m_rem[i] = (m_rem[i] > 0) ? m_rem[i] - 1 : int'(m_lfsr[i][10:8]);
                if (en) m_lfsr[i] = lfsr_next(m_lfsr[i]);
            end
        end
        #1;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) m_st[i] = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit          en, v, r;
        bit          exp_vo, exp_ro, exp_st;
        logic [3:0]  exp_cnt;
    } vec_t;

    vec_t tbl [19];

    initial begin
        int hs;
        int seen;
        logic [29:0] pat1, pat2;
        int cyc;
        bit found;

        thr_m  = '{0, 256, 128};
        cmax_m = '{64'hFFFF_FFFF, 64'd15, 64'hFFFF_FFFF};
        model_reset();
        en = 1'b0; vin = 1'b0; rin = 1'b0; din = '0;

        // Enable window then hold protection on instance B (always stall).
        for (int i = 0; i < 10; i++) tbl[i] = '{1, 1, 1, 0, 0, 1, 4'(i)};
        tbl[10] = '{0, 1, 1, 1, 1, 0, 4'd10};
        tbl[11] = '{0, 0, 1, 0, 1, 0, 4'd10};
        for (int i = 12; i < 15; i++) tbl[i] = '{0, 1, 0, 1, 0, 0, 4'd10};
        tbl[15] = '{1, 1, 0, 1, 0, 0, 4'd10};
        tbl[16] = '{1, 1, 0, 1, 0, 0, 4'd10};
        tbl[17] = '{1, 1, 1, 1, 1, 0, 4'd10};
        tbl[18] = '{1, 1, 1, 0, 0, 1, 4'd10};

        do_reset();
        check("reset_cnt_a", 64'(cnt_a), 64'd0);
        check("reset_cnt_b", 64'(cnt_b), 64'd0);

        for (int i = 0; i < 19; i++) begin
            en = tbl[i].en; vin = tbl[i].v; rin = tbl[i].r; din = $urandom;
            sample();
            check($sformatf("tbl%0d_hs", i), {61'b0, vo[1], ro[1], so[1]},
                  {61'b0, tbl[i].exp_vo, tbl[i].exp_ro, tbl[i].exp_st});
            check($sformatf("tbl%0d_cnt", i), 64'(cnt_b), 64'(tbl[i].exp_cnt));
            advance();
        end
        check("after_tbl_cnt_b", 64'(cnt_b), 64'd11);

        // Counter saturation.
        en = 1'b1; vin = 1'b1; rin = 1'b1;
        for (int i = 0; i < 20; i++) cycle();
        check("sat_cnt_b", 64'(cnt_b), 64'd15);
        for (int i = 0; i < 5; i++) cycle();
        check("sat_hold_cnt_b", 64'(cnt_b), 64'd15);

        // Never stall: 100 back-to-back beats on instance A.
        hs = 0; seen = 0;
        for (int i = 0; i < 100; i++) begin
            din = $urandom;
            sample();
            if (vo[0] && rin) hs++;
            if (so[0]) seen++;
            advance();
        end
        check("never_hs", 64'(hs), 64'd100);
        check("never_stall_seen", 64'(seen), 64'd0);
        check("never_cnt_a", 64'(cnt_a), 64'd0);

        // Reset mid-stall on instance C; the pattern must repeat after release.
        en = 1'b0;
        do_reset();
        en = 1'b1; vin = 1'b1; rin = 1'b1;
        for (int i = 0; i < 30; i++) begin
            sample();
            pat1[i] = so[2];
            advance();
        end
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            sample();
            if (so[2]) begin
                found = 1'b1;
                rst_n = 1'b0;
                #1;
                check("rst_mid_stall", {61'b0, so[2], vo[2], ro[2]}, {61'b0, 1'b0, vin, rin});
            end
            advance();
        end
        check("rst_stall_found", {63'b0, found}, 64'd1);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            sample();
            pat2[i] = so[2];
            advance();
        end
        check("rst_pattern_repeat", 64'(pat2), 64'(pat1));

        // Random stress on instance C with a legal upstream.
        stress_on = 1'b1;
        prev_vo = 1'b0;
        vin = 1'b0;
        cyc = 0;
        while (beats < 10000 && cyc < 60000) begin
            if (!(vin && !up_hs)) begin
                vin = ($urandom_range(0, 3) != 0);
                din = $urandom;
            end
            rin = ($urandom_range(0, 3) != 0);
            en  = ($urandom_range(0, 15) != 0);
            cycle();
            cyc++;
        end
        check("stress_beats", 64'(beats), 64'd10000);
        check("stress_watchdog", {63'b0, wd_max < 64}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
